// File: rtl/vend_credit_fsm_pkg.sv
// Shared coin codes, coin values and FSM state encodings for the vending credit path.
// Also used by the change picker and the future refund unit.
package vend_credit_fsm_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    localparam int unsigned VAL_NICKEL  = 5;
    localparam int unsigned VAL_DIME    = 10;
    localparam int unsigned VAL_QUARTER = 25;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_VEND    = 2'b10,
        S_CHANGE  = 2'b11
    } state_t;

    function automatic int unsigned coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  return VAL_NICKEL;
            COIN_DIME:    return VAL_DIME;
            COIN_QUARTER: return VAL_QUARTER;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit_fsm_change_sel.sv
// Greedy change picker: largest coin not exceeding the remaining credit.
// Purely combinational so a refund unit can share it.
module vend_change_sel
    import vend_credit_fsm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output coin_t               coin,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        coin  = COIN_NICKEL;
        value = CREDIT_W'(VAL_NICKEL);
        if (credit >= CREDIT_W'(VAL_QUARTER)) begin
            coin  = COIN_QUARTER;
            value = CREDIT_W'(VAL_QUARTER);
        end else if (credit >= CREDIT_W'(VAL_DIME)) begin
            coin  = COIN_DIME;
            value = CREDIT_W'(VAL_DIME);
        end
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-credit controller: accumulates coins, pulses dispense at PRICE,
// then pays back excess (or everything on cancel) one greedy coin per cycle.
module vend_credit_fsm
    import vend_credit_fsm_pkg::*;
#(
    parameter int PRICE    = 65,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          fsm_state
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // coin_valid and cancel are single-cycle strobes with no back-pressure:
    // a strobe is consumed on the rising edge it is seen, accepted or refused.
    state_t              state;
    logic                coin_accept;
    logic                coin_refuse;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] credit_after_vend;
    logic [CREDIT_W-1:0] credit_after_change;
    coin_t               sel_coin;
    logic [CREDIT_W-1:0] sel_value;

    vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
        .credit (credit),
        .coin   (sel_coin),
        .value  (sel_value)
    );

    assign coin_accept = coin_valid && (coin_type != COIN_NONE) && !cancel
                         && ((state == S_IDLE) || (state == S_COLLECT));
    assign coin_refuse = coin_valid && !coin_accept;

    // PRICE+20 fits in CREDIT_W, so a quarter on top of sub-PRICE credit cannot wrap.
    assign credit_sum          = credit + CREDIT_W'(coin_value(coin_type));
    assign credit_after_vend   = credit - PRICE_C;
    assign credit_after_change = credit - sel_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            credit      <= '0;
            dispense    <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            coin_reject <= coin_refuse;
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (coin_accept) begin
                        credit <= credit_sum;
                        if (credit_sum >= PRICE_C) begin
                            state    <= S_VEND;
                            dispense <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end else if (cancel && (state == S_COLLECT)) begin
                        state <= S_CHANGE;
                    end
                end
                S_VEND: begin
                    credit <= credit_after_vend;
                    state  <= (credit_after_vend != '0) ? S_CHANGE : S_IDLE;
                end
                S_CHANGE: begin
                    credit <= credit_after_change;
                    if (credit_after_change == '0) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign change_valid = (state == S_CHANGE);
    assign change_coin  = change_valid ? sel_coin : COIN_NONE;
    assign busy         = (state == S_VEND) || (state == S_CHANGE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm with PRICE=65: coin sequences, cancel,
// refused coins and asynchronous reset in the middle of change payout.
module tb_vend_credit_fsm;

    localparam int CREDIT_W = 8;
    localparam logic [1:0] NONE = 2'b00, NICKEL = 2'b01, DIME = 2'b10, QUARTER = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'b00, ST_COLLECT = 2'b01, ST_VEND = 2'b10, ST_CHANGE = 2'b11;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin_type = 2'b00;
    logic                cancel = 1'b0;
    logic                dispense;
    logic                change_valid;
    logic [1:0]          change_coin;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          fsm_state;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    vend_credit_fsm #(.PRICE(65), .CREDIT_W(CREDIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .busy         (busy),
        .credit       (credit),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] t, input logic with_cancel);
        coin_valid = 1'b1;
        coin_type  = t;
        cancel     = with_cancel;
        tick();
        coin_valid = 1'b0;
        coin_type  = NONE;
        cancel     = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Pops the expected change coins one per cycle, then expects IDLE with zero credit.
    task automatic drain_change(input string tag);
        while (exp_q.size() > 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check({tag, " change_valid"}, int'(change_valid), 1);
            check({tag, " change_coin"}, int'(change_coin), int'(e));
            check({tag, " no dispense"}, int'(dispense), 0);
            tick();
        end
        check({tag, " end change_valid"}, int'(change_valid), 0);
        check({tag, " end credit"}, int'(credit), 0);
        check({tag, " end state"}, int'(fsm_state), int'(ST_IDLE));
        check({tag, " end busy"}, int'(busy), 0);
    endtask

    initial begin
        // reset values
        #2;
        check("rst credit", int'(credit), 0);
        check("rst state", int'(fsm_state), int'(ST_IDLE));
        check("rst dispense", int'(dispense), 0);
        check("rst change_valid", int'(change_valid), 0);
        check("rst coin_reject", int'(coin_reject), 0);
        tick();
        rst = 1'b0;
        tick();

        // 3 quarters: 25, 50, 75 -> dispense -> dime change
        put_coin(QUARTER, 1'b0);
        check("q1 credit", int'(credit), 25);
        check("q1 state", int'(fsm_state), int'(ST_COLLECT));
        put_coin(QUARTER, 1'b0);
        check("q2 credit", int'(credit), 50);
        check("q2 dispense", int'(dispense), 0);
        put_coin(QUARTER, 1'b0);
        check("q3 credit", int'(credit), 75);
        check("q3 dispense", int'(dispense), 1);
        check("q3 busy", int'(busy), 1);
        check("q3 change_valid", int'(change_valid), 0);
        tick();
        check("q3 credit after vend", int'(credit), 10);
        exp_q.push_back(DIME);
        drain_change("3q");

        // dime + nickel, then cancel: refund dime then nickel
        put_coin(DIME, 1'b0);
        put_coin(NICKEL, 1'b0);
        check("dn credit", int'(credit), 15);
        do_cancel();
        check("cancel state", int'(fsm_state), int'(ST_CHANGE));
        check("cancel credit", int'(credit), 15);
        exp_q.push_back(DIME);
        exp_q.push_back(NICKEL);
        drain_change("cancel");

        // cancel in IDLE is ignored
        do_cancel();
        check("idle cancel state", int'(fsm_state), int'(ST_IDLE));
        check("idle cancel change_valid", int'(change_valid), 0);

        // invalid coin code in IDLE
        put_coin(NONE, 1'b0);
        check("inv reject", int'(coin_reject), 1);
        check("inv credit", int'(credit), 0);
        tick();
        check("inv reject one cycle", int'(coin_reject), 0);

        // quarter during VEND is refused
        put_coin(QUARTER, 1'b0);
        put_coin(QUARTER, 1'b0);
        put_coin(QUARTER, 1'b0);
        check("vend state", int'(fsm_state), int'(ST_VEND));
        put_coin(QUARTER, 1'b0);
        check("vend coin reject", int'(coin_reject), 1);
        check("vend coin credit", int'(credit), 10);
        check("vend coin state", int'(fsm_state), int'(ST_CHANGE));
        check("dispense one cycle", int'(dispense), 0);
        exp_q.push_back(DIME);
        drain_change("vendcoin");
        check("vendcoin reject cleared", int'(coin_reject), 0);

        // quarter with cancel at credit 30: refused, refund 30
        put_coin(QUARTER, 1'b0);
        put_coin(NICKEL, 1'b0);
        check("c30 credit", int'(credit), 30);
        put_coin(QUARTER, 1'b1);
        check("c30 reject", int'(coin_reject), 1);
        check("c30 credit kept", int'(credit), 30);
        exp_q.push_back(QUARTER);
        exp_q.push_back(NICKEL);
        drain_change("c30");

        // exact price 25+25+10+5 = 65: dispense, no change
        put_coin(QUARTER, 1'b0);
        put_coin(QUARTER, 1'b0);
        put_coin(DIME, 1'b0);
        check("exact 60", int'(credit), 60);
        put_coin(NICKEL, 1'b0);
        check("exact dispense", int'(dispense), 1);
        check("exact credit", int'(credit), 65);
        tick();
        check("exact no change", int'(change_valid), 0);
        check("exact state", int'(fsm_state), int'(ST_IDLE));
        check("exact credit 0", int'(credit), 0);
        check("exact dispense off", int'(dispense), 0);

        // async reset in the middle of CHANGE with credit 10
        put_coin(QUARTER, 1'b0);
        put_coin(QUARTER, 1'b0);
        put_coin(QUARTER, 1'b0);
        tick();
        check("pre-rst state", int'(fsm_state), int'(ST_CHANGE));
        check("pre-rst credit", int'(credit), 10);
        #2;
        rst = 1'b1;
        #1;
        check("async rst credit", int'(credit), 0);
        check("async rst state", int'(fsm_state), int'(ST_IDLE));
        check("async rst change_valid", int'(change_valid), 0);
        check("async rst busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post-rst change_valid", int'(change_valid), 0);
        check("post-rst credit", int'(credit), 0);
        check("post-rst state", int'(fsm_state), int'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
